div_8: RTL and testbench

- Sequential 8-bit unsigned restoring divider, the inverse operation to the lab's 8-bit array multiplier.
- Operands are loaded from one switch bus into dividend and divisor registers.
- A start pulse runs N shift-subtract iterations, one per clock.
- The quotient and remainder are registered and shown on four hex digits through the shared hex_display_decoder.

---
 rtl/div_8_pkg.sv | 17 +
 rtl/hex_display_decoder.sv | 32 +++
 rtl/n_bit_pipo.sv | 21 ++
 rtl/n_bit_restoring_div.sv | 110 +++++++++++
 rtl/div_8.sv | 65 ++++++
 tb/tb_div_8.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/div_8_pkg.sv
// Shared definitions for the 8-bit restoring divider and its display path.
package div_8_pkg;

  // Default operand width; the four-digit display mapping assumes 8.
  localparam int DIV_N = 8;

  // Width of one seven-segment digit pattern (a..g plus decimal point).
  localparam int SEG_W = 8;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_display_decoder.sv
// Hex nibble to seven-segment pattern, active-low, bit order {dp,g,f,e,d,c,b,a}.
// The decimal point is always off.
module hex_display_decoder (
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Pure lookup from the nibble value to its glyph.
  always_comb begin
    seg = 8'hFF;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/n_bit_pipo.sv
// Parallel-in parallel-out register with load enable and async active-low clear.
module n_bit_pipo #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Capture d when load is high; otherwise hold.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/n_bit_restoring_div.sv
// Sequential restoring divider: one shift-subtract step per clock, N steps.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
// The current state is exported so the wrapper can gate operand loads.
module n_bit_restoring_div
  import div_8_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output state_t       state
);

  localparam int CNT_W = $clog2(N + 1);

  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     work_rem;
  logic [N-1:0]     work_quo;
  logic [N:0]       trial;
  logic [N-1:0]     step_rem;
  logic [N-1:0]     step_quo;
  logic             zero_div;
  logic             last_iter;

  // One restoring step: a non-negative trial difference sets the quotient bit.
  assign trial     = {work_rem, work_quo[N-1]} - {1'b0, divisor};
  assign step_rem  = trial[N] ? {work_rem[N-2:0], work_quo[N-1]} : trial[N-1:0];
  assign step_quo  = {work_quo[N-2:0], ~trial[N]};
  assign zero_div  = (divisor == '0);
  assign last_iter = (count == CNT_W'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: seed on start, iterate in RUN, publish results only when complete.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count       <= '0;
      work_rem    <= '0;
      work_quo    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              work_rem    <= '0;
              work_quo    <= dividend;
              count       <= CNT_W'(N);
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          work_rem <= step_rem;
          work_quo <= step_quo;
          count    <= count - CNT_W'(1);
          if (last_iter) begin
            quotient  <= step_quo;
            remainder <= step_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/div_8.sv
// 8-bit unsigned divider with switch-bus operand loading and a four-digit
// hex display: remainder on the upper two digits, quotient on the lower two.
module div_8
  import div_8_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] data_in,
  input  logic         load_a,
  input  logic         load_b,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [31:0]  segment
);

  state_t       state;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         load_ok;

  // Operands are frozen while a division is iterating.
  assign load_ok = (state != RUN);

  n_bit_pipo #(.N(N)) u_dividend (
    .clk  (clk),
    .clr  (clr),
    .load (load_a & load_ok),
    .d    (data_in),
    .q    (dividend)
  );

  n_bit_pipo #(.N(N)) u_divisor (
    .clk  (clk),
    .clr  (clr),
    .load (load_b & load_ok),
    .d    (data_in),
    .q    (divisor)
  );

  n_bit_restoring_div #(.N(N)) u_div (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .state       (state)
  );

  hex_display_decoder u_hex_q0 (.hex(quotient[3:0]),  .seg(segment[SEG_W-1:0]));
  hex_display_decoder u_hex_q1 (.hex(quotient[7:4]),  .seg(segment[2*SEG_W-1:SEG_W]));
  hex_display_decoder u_hex_r0 (.hex(remainder[3:0]), .seg(segment[3*SEG_W-1:2*SEG_W]));
  hex_display_decoder u_hex_r1 (.hex(remainder[7:4]), .seg(segment[4*SEG_W-1:3*SEG_W]));

endmodule

// File: tb/tb_div_8.sv
// Bench for div_8: scoreboard of expected {quotient, remainder, div_by_zero}
// pushed at each start and popped when done is observed.
module tb_div_8;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  data_in;
  logic        load_a;
  logic        load_b;
  logic        start;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic [31:0] segment;

  div_8 dut (
    .clk         (clk),
    .clr         (clr),
    .data_in     (data_in),
    .load_a      (load_a),
    .load_b      (load_b),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder),
    .segment     (segment)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  cur_a   = 8'h00;
  logic [7:0]  cur_b   = 8'h00;
  logic [7:0]  shown_q = 8'h00;
  logic [7:0]  shown_r = 8'h00;

  // Active-low {dp,g,f,e,d,c,b,a} glyphs for 0..F
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [31:0] seg_model(input logic [7:0] q, input logic [7:0] r);
    return {seg_tab[r[7:4]], seg_tab[r[3:0]], seg_tab[q[7:4]], seg_tab[q[3:0]]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic load(input bit la, input bit lb, input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    load_a  = la;
    load_b  = lb;
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    if (la) cur_a = v;
    if (lb) cur_b = v;
  endtask

  task automatic push_exp();
    if (cur_b == 8'h00) exp_q.push_back({8'hFF, cur_a, 1'b1});
    else                exp_q.push_back({cur_a / cur_b, cur_a % cur_b, 1'b0});
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    check("start_busy", 32'(busy), 32'(cur_b != 8'h00));
    check("start_done", 32'(done), 32'(cur_b == 8'h00));
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Wait (bounded) for done, checking the display holds meanwhile, then score.
  task automatic finish_div(input bit inject);
    int          k;
    int          exp_lat;
    logic [16:0] e;
    k = 0;
    exp_lat = (exp_q.size() != 0 && exp_q[0][0]) ? 0 : 8;
    while (!done && k < 40) begin
      check("run_busy", 32'(busy), 32'd1);
      check("hold_q", 32'(quotient), 32'(shown_q));
      check("hold_r", 32'(remainder), 32'(shown_r));
      if (inject && k == 2) begin
        data_in = 8'h11;
        load_a  = 1'b1;
        start   = 1'b1;
      end
      if (inject && k == 3) begin
        load_a = 1'b0;
        start  = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 32'(k), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("quotient", 32'(quotient), 32'(e[16:9]));
      check("remainder", 32'(remainder), 32'(e[8:1]));
      check("div_by_zero", 32'(div_by_zero), 32'(e[0]));
      check("segment", segment, seg_model(e[16:9], e[8:1]));
      shown_q = e[16:9];
      shown_r = e[8:1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    clr = 1'b0; data_in = 8'h00; load_a = 1'b0; load_b = 1'b0; start = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_seg", segment, seg_model(8'h00, 8'h00));
    repeat (2) @(negedge clk);
    clr = 1'b1;

    // Basic divisions
    load(1, 0, 8'd200); load(0, 1, 8'd7); launch(0); finish_div(0);
    load(1, 0, 8'hFF);  load(0, 1, 8'h01); launch(0); finish_div(0);
    load(1, 0, 8'd5);   load(0, 1, 8'd9);  launch(0); finish_div(0);
    load(1, 1, 8'd12);  launch(0); finish_div(0);
    load(1, 0, 8'h42);  load(0, 1, 8'h00); launch(0); finish_div(0);

    // Load and start during RUN are ignored; rerun proves dividend kept 200
    load(1, 0, 8'd200); load(0, 1, 8'd7); launch(0); finish_div(1);
    launch(0); finish_div(0);

    // Loading in DONE keeps done and the displayed result
    load(0, 1, 8'd10);
    check("load_keeps_done", 32'(done), 32'd1);
    check("load_keeps_q", 32'(quotient), 32'(shown_q));
    launch(0); finish_div(0);

    // Held start in DONE restarts on the next edge
    launch(1); finish_div(0);
    @(posedge clk);
    #1;
    push_exp();
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_done", 32'(done), 32'd0);
    start = 1'b0;
    finish_div(0);

    // Asynchronous reset mid-run
    load(1, 0, 8'd200); load(0, 1, 8'd7); launch(0);
    repeat (3) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_seg", segment, seg_model(8'h00, 8'h00));
    exp_q.delete();
    shown_q = 8'h00; shown_r = 8'h00; cur_a = 8'h00; cur_b = 8'h00;
    @(negedge clk);
    clr = 1'b1;
    load(1, 0, 8'd100); load(0, 1, 8'd10); launch(0); finish_div(0);

    // Random operands, divisor sometimes zero
    repeat (8) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 20));
      load(1, 0, ra); load(0, 1, rb); launch(0); finish_div(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
